game_control: RTL and testbench

GAME_CONTROL -- requirements
Module: game_control

---
 rtl/game_control_pkg.sv | 44 ++++
 rtl/game_control_tick_gen.sv | 61 ++++++
 rtl/game_control.sv | 184 ++++++++++++++++++
 tb/tb_game_control.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_control_pkg.sv
// ---------------------------------------------------------------------------
// game_control_pkg
//   Shared definitions for the game controller and the sprite controllers:
//   game state encoding, default tick timing, score width and saturation
//   value, and the period decrement/floor helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package game_control_pkg;

  localparam int unsigned PERIOD_W = 20;
  localparam int unsigned SCORE_W  = 10;

  localparam int unsigned TICK_START_DEF = 750000;
  localparam int unsigned TICK_MIN_DEF   = 250000;
  localparam int unsigned TICK_STEP_DEF  = 100;
  localparam int unsigned SCORE_MAX_DEF  = 999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [SCORE_W-1:0]  score_t;

  // Next tick period: subtract the step only when the result stays at or
  // above the floor. The comparison is done one bit wider so floor + step
  // cannot wrap, and the subtraction therefore can never underflow.
  function automatic period_t next_period(input period_t cur,
                                          input period_t floor_val,
                                          input period_t step);
    logic [PERIOD_W:0] limit;
    period_t           result;
    limit = {1'b0, floor_val} + {1'b0, step};
    if ({1'b0, cur} >= limit) begin
      result = cur - step;
    end else begin
      result = floor_val;
    end
    return result;
  endfunction

endpackage

// File: rtl/game_control_tick_gen.sv
// ---------------------------------------------------------------------------
// game_control_tick_gen
//   Programmable-period game tick generator. The counter runs 0..period-1
//   while enabled; on the wrap cycle the period shrinks by the step (down to
//   the floor) and game_tick pulses high for one cycle on the following
//   cycle.
//
//   Ports
//     CLOCK_50   in   system clock
//     reset      in   asynchronous, active-high reset
//     load       in   restart: counter := 0, period := TICK_START, no pulse
//     enable     in   counting allowed (RUN and no collision this cycle)
//     game_tick  out  one-cycle pulse, the cycle after a wrap
//     wrap       out  combinational: counter wraps on this edge
// ---------------------------------------------------------------------------
module game_control_tick_gen
  import game_control_pkg::*;
#(
  parameter int unsigned TICK_START = TICK_START_DEF,
  parameter int unsigned TICK_MIN   = TICK_MIN_DEF,
  parameter int unsigned TICK_STEP  = TICK_STEP_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic game_tick,
  output logic wrap
);

  localparam period_t PERIOD_START = period_t'(TICK_START);
  localparam period_t PERIOD_FLOOR = period_t'(TICK_MIN);
  localparam period_t PERIOD_STEP  = period_t'(TICK_STEP);

  period_t count;
  period_t period;

  // The period never drops below TICK_MIN (>= 1), so period - 1 is safe.
  assign wrap = enable && (count == (period - period_t'(1)));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count     <= '0;
      period    <= PERIOD_START;
      game_tick <= 1'b0;
    end else if (load) begin
      count     <= '0;
      period    <= PERIOD_START;
      game_tick <= 1'b0;
    end else begin
      game_tick <= wrap;
      if (wrap) begin
        count  <= '0;
        period <= next_period(period, PERIOD_FLOOR, PERIOD_STEP);
      end else if (enable) begin
        count <= count + period_t'(1);
      end
    end
  end

endmodule

// File: rtl/game_control.sv
// ---------------------------------------------------------------------------
// game_control
//   Top-level game sequencer: start button synchronisation, frame-end
//   collision detection, game state machine, score and best score, and the
//   game tick generator.
//
//   Ports
//     CLOCK_50          in   system clock, single domain
//     reset             in   asynchronous, active-high reset
//     start_n           in   start/restart button, active-low, asynchronous
//     vsync             in   VGA vertical sync, active-low, CLOCK_50 domain
//     player_drawing    in   player sprite covers the current pixel
//     obstacle_drawing  in   [4:0] obstacle N sprite covers the current pixel
//     game_tick         out  one-cycle motion pulse, RUN only
//     score             out  [9:0] current score, saturating
//     max_score         out  [9:0] best score since reset
//     game_over         out  high in OVER
//     running           out  high in RUN
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | after reset, waiting for the first start press
//   ST_RUN  | game in progress, ticks advance motion and score
//   ST_OVER | collision seen, score frozen, waiting for a restart press
// ---------------------------------------------------------------------------
module game_control
  import game_control_pkg::*;
#(
  parameter int unsigned TICK_START = TICK_START_DEF,
  parameter int unsigned TICK_MIN   = TICK_MIN_DEF,
  parameter int unsigned TICK_STEP  = TICK_STEP_DEF,
  parameter int unsigned SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         start_n,
  input  logic         vsync,
  input  logic         player_drawing,
  input  logic [4:0]   obstacle_drawing,
  output logic         game_tick,
  output logic [9:0]   score,
  output logic [9:0]   max_score,
  output logic         game_over,
  output logic         running
);

  localparam score_t SCORE_LIMIT = score_t'(SCORE_MAX);

  game_state_t state;
  game_state_t state_nxt;

  logic       start_sync1;
  logic       start_sync2;
  logic       start_prev;
  logic [1:0] sync_valid;
  logic       start_armed;
  logic       start_evt;

  logic       vsync_q;
  logic       frame_end;

  logic       overlap;
  logic       hit;
  logic       collision;

  logic       load;
  logic       tick_enable;
  logic       tick_wrap;

  // Start button: two-flop synchronizer plus an edge register. The flops
  // reset to the released level, so a button held down across reset release
  // would look like a press. sync_valid tracks when start_sync2 holds a real
  // sample of the pin, and presses are only accepted once the button has
  // been seen released after reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      start_sync1 <= 1'b1;
      start_sync2 <= 1'b1;
      start_prev  <= 1'b1;
      sync_valid  <= 2'b00;
      start_armed <= 1'b0;
    end else begin
      start_sync1 <= start_n;
      start_sync2 <= start_sync1;
      start_prev  <= start_sync2;
      sync_valid  <= {sync_valid[0], 1'b1};
      if (sync_valid[1] && start_sync2) begin
        start_armed <= 1'b1;
      end
    end
  end

  assign start_evt = start_armed && start_prev && !start_sync2;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign frame_end = vsync_q && !vsync;
  assign overlap   = player_drawing && (|obstacle_drawing);

  // An overlap on the frame-end cycle itself still counts for that frame.
  assign collision = (state == ST_RUN) && frame_end && (hit || overlap);

  // A collision suppresses a coincident counter wrap: no tick, no point.
  assign tick_enable = (state == ST_RUN) && !collision;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          state_nxt = ST_RUN;
          load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (collision) begin
          state_nxt = ST_OVER;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign running   = (state == ST_RUN);
  assign game_over = (state == ST_OVER);

  // The score advances on the wrap edge, the same edge that raises
  // game_tick, so score and pulse change together. The best score is
  // captured on the collision edge, which is the edge entering OVER.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      score     <= '0;
      max_score <= '0;
      hit       <= 1'b0;
    end else begin
      if (load) begin
        score <= '0;
      end else if (tick_wrap && (score < SCORE_LIMIT)) begin
        score <= score + score_t'(1);
      end

      if (collision && (score > max_score)) begin
        max_score <= score;
      end

      if (load || frame_end) begin
        hit <= 1'b0;
      end else if ((state == ST_RUN) && overlap) begin
        hit <= 1'b1;
      end
    end
  end

  game_control_tick_gen #(
    .TICK_START (TICK_START),
    .TICK_MIN   (TICK_MIN),
    .TICK_STEP  (TICK_STEP)
  ) u_tick_gen (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (load),
    .enable    (tick_enable),
    .game_tick (game_tick),
    .wrap      (tick_wrap)
  );

endmodule

// File: tb/tb_game_control.sv
// ---------------------------------------------------------------------------
// tb_game_control
//   Directed self-checking bench for game_control with
//   TICK_START=10, TICK_MIN=4, TICK_STEP=2.
// ---------------------------------------------------------------------------
module tb_game_control;

  logic       CLOCK_50;
  logic       reset;
  logic       start_n;
  logic       vsync;
  logic       player_drawing;
  logic [4:0] obstacle_drawing;
  logic       game_tick;
  logic [9:0] score;
  logic [9:0] max_score;
  logic       game_over;
  logic       running;

  int n_checks;
  int n_fail;

  game_control #(
    .TICK_START (10),
    .TICK_MIN   (4),
    .TICK_STEP  (2)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .start_n          (start_n),
    .vsync            (vsync),
    .player_drawing   (player_drawing),
    .obstacle_drawing (obstacle_drawing),
    .game_tick        (game_tick),
    .score            (score),
    .max_score        (max_score),
    .game_over        (game_over),
    .running          (running)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until game_tick is seen high; gives up after 64 cycles.
  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while ((game_tick !== 1'b1) && (gap < 64));
  endtask

  // Press start for three edges: two synchronizer flops plus the state edge.
  task automatic press_start();
    start_n = 1'b0;
    step();
    step();
    step();
    start_n = 1'b1;
  endtask

  int exp_gap [6] = '{10, 8, 6, 4, 4, 4};
  int gap;
  int timeouts;
  bit saw_tick;

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    start_n          = 1'b1;
    vsync            = 1'b1;
    player_drawing   = 1'b0;
    obstacle_drawing = 5'b00000;

    // Reset state
    step();
    step();
    check("rst_score",     score,     0);
    check("rst_max_score", max_score, 0);
    check("rst_running",   running,   0);
    check("rst_game_over", game_over, 0);
    check("rst_game_tick", game_tick, 0);
    reset = 1'b0;
    repeat (4) step();
    check("idle_running", running, 0);

    // Game 1: start, tick gaps shrink 10,8,6 then floor at 4
    press_start();
    check("start_running", running, 1);
    check("start_score",   score,   0);
    for (int i = 0; i < 6; i++) begin
      wait_tick(gap);
      check($sformatf("gap_%0d", i), gap, exp_gap[i]);
      check($sformatf("score_after_tick_%0d", i), score, i + 1);
    end
    wait_tick(gap);
    check("gap_6", gap, 4);
    check("game1_score", score, 7);

    // One-cycle overlap mid-frame, frame end on the following cycle
    player_drawing   = 1'b1;
    obstacle_drawing = 5'b00100;
    step();
    player_drawing   = 1'b0;
    obstacle_drawing = 5'b00000;
    vsync            = 1'b0;
    step();
    vsync = 1'b1;
    check("hit_game_over", game_over, 1);
    check("hit_running",   running,   0);
    check("hit_max_score", max_score, 7);
    saw_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (game_tick !== 1'b0) saw_tick = 1'b1;
    end
    check("over_no_tick",    saw_tick, 0);
    check("over_score_held", score,    7);

    // Game 2: restart from OVER, a start press in RUN is ignored, then a
    // collision lands on the same edge as the counter wrap.
    press_start();
    check("restart_running",   running,   1);
    check("restart_game_over", game_over, 0);
    check("restart_score",     score,     0);
    repeat (5) step();
    start_n = 1'b0;
    repeat (4) step();
    start_n = 1'b1;
    repeat (18) step();
    check("game2_score_before_hit", score, 3);
    vsync            = 1'b0;
    player_drawing   = 1'b1;
    obstacle_drawing = 5'b10000;
    step();
    vsync            = 1'b1;
    player_drawing   = 1'b0;
    obstacle_drawing = 5'b00000;
    check("coincide_game_over", game_over, 1);
    check("coincide_game_tick", game_tick, 0);
    check("coincide_score",     score,     3);
    check("coincide_max_score", max_score, 7);

    // Score saturation after a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_max_score", max_score, 0);
    repeat (4) step();
    press_start();
    timeouts = 0;
    for (int i = 0; i < 998; i++) begin
      wait_tick(gap);
      if (gap >= 64) timeouts++;
    end
    check("sat_timeouts",  timeouts, 0);
    check("sat_score_998", score,    998);
    for (int i = 0; i < 3; i++) begin
      wait_tick(gap);
      check($sformatf("sat_gap_%0d", i),   gap,   4);
      check($sformatf("sat_score_%0d", i), score, 999);
    end

    // Asynchronous reset between edges with a wrap pending on the next edge
    repeat (3) step();
    #2;
    reset   = 1'b1;
    start_n = 1'b0;
    #1;
    check("arst_score",     score,     0);
    check("arst_max_score", max_score, 0);
    check("arst_running",   running,   0);
    check("arst_game_over", game_over, 0);
    check("arst_game_tick", game_tick, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    check("held_start_running", running,   0);
    check("held_start_tick",     game_tick, 0);
    start_n = 1'b1;
    repeat (4) step();
    press_start();
    check("post_reset_running", running, 1);
    check("post_reset_score",   score,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
